vc_credit_tx: RTL and testbench

//  Transmit end of an inter-router link with credit-based flow control.
//  - Accepts flits tagged with a VC id from the switch-traversal stage.
//  - Tracks downstream buffer credits per VC, blocks sends when a VC has no credit.
//  - Registers accepted flits onto the link; credits are returned by the downstream input buffer.

---
 rtl/vc_router_pkg.sv | 12 +
 rtl/pipe_register.sv | 14 +
 rtl/vc_credit_counter.sv | 23 ++
 rtl/vc_credit_tx.sv | 57 +++++
 tb/tb_vc_credit_tx.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/vc_router_pkg.sv
// vc_router_pkg: shared link parameters and flit types for the router datapath
package vc_router_pkg;
  localparam int NUM_VC = 4;
  localparam int BUF_DEPTH = 4;
  localparam int DATAW = 32;
  localparam int VCW = $clog2(NUM_VC);
  typedef logic [VCW-1:0] vc_id_t;
  typedef struct packed {
    vc_id_t vc;
    logic [DATAW-1:0] data;
  } flit_t;
endpackage

// File: rtl/pipe_register.sv
// pipe_register: enabled pipeline register cleared by synchronous reset
module pipe_register #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DATAW-1:0] d,
  output logic [DATAW-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/vc_credit_counter.sv
// vc_credit_counter: per-VC downstream credit counter, saturating at buffer depth
module vc_credit_counter #(
  parameter int BUF_DEPTH = vc_router_pkg::BUF_DEPTH,
  parameter int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          nonzero,
  output logic          overflow
);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  logic full;
  assign full = (cnt == FULL);
  assign nonzero = (cnt != '0);
  assign overflow = inc & ~dec & full;
  always_ff @(posedge clk)
    if (reset) cnt <= FULL;
    else if (dec & ~inc) cnt <= cnt - 1'b1;
    else if (inc & ~dec & ~full) cnt <= cnt + 1'b1;
endmodule

// File: rtl/vc_credit_tx.sv
// vc_credit_tx: credit-flow-controlled link transmitter with per-VC credit tracking
module vc_credit_tx
  import vc_router_pkg::*;
#(
  parameter int NUM_VC = vc_router_pkg::NUM_VC,
  parameter int BUF_DEPTH = vc_router_pkg::BUF_DEPTH,
  parameter int DATAW = vc_router_pkg::DATAW,
  parameter int VCW = $clog2(NUM_VC),
  parameter int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [VCW-1:0]       in_vc,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [VCW-1:0]       out_vc,
  output logic [DATAW-1:0]     out_data,
  input  logic                 credit_valid,
  input  logic [VCW-1:0]       credit_vc,
  output logic [NUM_VC*CW-1:0] credit_cnt,
  output logic                 credit_err
);
  localparam int OW = 1 + VCW + DATAW;
  logic [NUM_VC-1:0] nonzero, overflow;
  logic accept;
  logic [OW-1:0] stage_d, stage_q;
  assign in_ready = nonzero[in_vc];
  assign accept = in_valid & in_ready;
  genvar v;
  generate
    for (v = 0; v < NUM_VC; v++) begin : g_vc
      vc_credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) u_cnt (
        .clk(clk),
        .reset(reset),
        .dec(accept & (in_vc == VCW'(v))),
        .inc(credit_valid & (credit_vc == VCW'(v))),
        .cnt(credit_cnt[v*CW +: CW]),
        .nonzero(nonzero[v]),
        .overflow(overflow[v])
      );
    end
  endgenerate
  assign stage_d = {accept, accept ? {in_vc, in_data} : {out_vc, out_data}};
  pipe_register #(.DATAW(OW)) u_out (
    .clk(clk),
    .reset(reset),
    .en(1'b1),
    .d(stage_d),
    .q(stage_q)
  );
  assign {out_valid, out_vc, out_data} = stage_q;
  always_ff @(posedge clk)
    if (reset) credit_err <= 1'b0;
    else if (|overflow) credit_err <= 1'b1;
endmodule

// File: tb/tb_vc_credit_tx.sv
// tb_vc_credit_tx: directed self-checking bench for vc_credit_tx
module tb_vc_credit_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_vc;
  logic [31:0] out_data;
  logic        credit_valid;
  logic [1:0]  credit_vc;
  logic [11:0] credit_cnt;
  logic        credit_err;
  int compared = 0;
  int mismatched = 0;

  vc_credit_tx dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_vc(out_vc), .out_data(out_data),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_vc = '0; in_data = '0;
    credit_valid = 1'b0; credit_vc = '0;
    tick; tick;
    reset = 1'b0;
    // 1: reset state
    chk("rst_cnt", credit_cnt, 12'h924);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vc", out_vc, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", credit_err, 0);
    for (int v = 0; v < 4; v++) begin
      in_vc = 2'(v);
      #1 chk($sformatf("rst_ready_vc%0d", v), in_ready, 1);
    end
    tick;
    chk("idle_out_valid", out_valid, 0);
    // 2: drain VC1
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_vc = 2'd1; in_data = 32'hA0 + 32'(i);
      #1 chk($sformatf("drain_ready%0d", i), in_ready, 1);
      tick;
      chk($sformatf("drain_valid%0d", i), out_valid, 1);
      chk($sformatf("drain_vc%0d", i), out_vc, 1);
      chk($sformatf("drain_data%0d", i), out_data, 32'hA0 + 32'(i));
    end
    chk("drain_cnt", credit_cnt, 12'h904);
    in_data = 32'hA4;
    #1 chk("drain_ready_blocked", in_ready, 0);
    tick;
    chk("drain_no_valid", out_valid, 0);
    chk("drain_hold_data", out_data, 32'hA3);
    chk("drain_hold_vc", out_vc, 1);
    chk("drain_cnt_stays", credit_cnt, 12'h904);
    // 3: refill VC1, no same-cycle bypass
    credit_valid = 1'b1; credit_vc = 2'd1; in_data = 32'hB0;
    #1 chk("refill_ready_N", in_ready, 0);
    tick;
    credit_valid = 1'b0;
    #1 chk("refill_ready_N1", in_ready, 1);
    chk("refill_cnt_N1", credit_cnt, 12'h90C);
    chk("refill_no_valid_N1", out_valid, 0);
    tick;
    in_valid = 1'b0;
    chk("refill_valid_N2", out_valid, 1);
    chk("refill_data_N2", out_data, 32'hB0);
    chk("refill_cnt_N2", credit_cnt, 12'h904);
    // 4: simultaneous send/credit
    in_valid = 1'b1; in_vc = 2'd2; in_data = 32'h20;
    tick;
    in_data = 32'h21;
    tick;
    chk("sim_pre_cnt", credit_cnt, 12'h884);
    in_data = 32'h22; credit_valid = 1'b1; credit_vc = 2'd2;
    tick;
    chk("sim_same_vc_cnt", credit_cnt, 12'h884);
    chk("sim_same_vc_data", out_data, 32'h22);
    in_vc = 2'd0; in_data = 32'h30; credit_vc = 2'd3;
    tick;
    in_valid = 1'b0; credit_valid = 1'b0;
    chk("sim_diff_vc_cnt", credit_cnt, 12'h883);
    chk("sim_diff_vc_out", {out_valid, out_vc, out_data}, {1'b1, 2'd0, 32'h30});
    chk("sim_sat_err", credit_err, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst2_err", credit_err, 0);
    chk("rst2_cnt", credit_cnt, 12'h924);
    // 5: overflow on VC0
    credit_valid = 1'b1; credit_vc = 2'd0;
    tick;
    credit_valid = 1'b0;
    chk("ovf_cnt", credit_cnt, 12'h924);
    chk("ovf_err", credit_err, 1);
    in_valid = 1'b1; in_vc = 2'd0; in_data = 32'h55;
    tick;
    in_valid = 1'b0; credit_valid = 1'b1; credit_vc = 2'd0;
    chk("ovf_traffic_cnt", credit_cnt, 12'h923);
    tick;
    credit_valid = 1'b0;
    chk("ovf_return_cnt", credit_cnt, 12'h924);
    chk("ovf_err_sticky", credit_err, 1);
    tick;
    chk("ovf_err_sticky2", credit_err, 1);
    // 6: reset mid-operation, pending credit dropped
    in_valid = 1'b1; in_vc = 2'd3; in_data = 32'hCC;
    tick;
    in_valid = 1'b0; reset = 1'b1; credit_valid = 1'b1; credit_vc = 2'd3;
    chk("mid_out_valid", out_valid, 1);
    chk("mid_out_data", out_data, 32'hCC);
    chk("mid_out_vc", out_vc, 3);
    tick;
    reset = 1'b0; credit_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cnt", credit_cnt, 12'h924);
    chk("mid_rst_err", credit_err, 0);
    tick;
    chk("post_rst_cnt", credit_cnt, 12'h924);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
